// File: rtl/pifo_sched_pkg.sv
// ----------------------------------------------------------------------------
// pifo_sched_pkg
// Shared definitions for the PIFO scheduler dequeue path.
//   - Default queue count and rank width of the dequeue arbiter.
//   - Bit layout of the root scheduling info word (pifo_info_root).
//   - CPU/DMA port index.
//   - Dequeue arbiter FSM state encoding.
// ----------------------------------------------------------------------------
package pifo_sched_pkg;

    localparam int NUM_QUEUES = 5;
    localparam int RANK_WIDTH = 16;

    // Ports 0-3 are the 10G MACs; the last queue feeds the CPU/DMA engine.
    localparam int CPU_PORT   = 4;

    // pifo_info_root layout
    localparam int ROOT_VALID_BIT  = 29;
    localparam int ROOT_RANK_MSB   = 28;
    localparam int ROOT_RANK_LSB   = 13;
    localparam int ROOT_ISLAST_BIT = 12;
    localparam int ROOT_FIELD_MSB  = 11;
    localparam int ROOT_FIELD_LSB  = 0;
    localparam int ROOT_INFO_W     = ROOT_VALID_BIT + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Pull the rank field out of a root info word.
    function automatic logic [RANK_WIDTH-1:0] root_rank(input logic [ROOT_INFO_W-1:0] info);
        return info[ROOT_RANK_MSB:ROOT_RANK_LSB];
    endfunction

endpackage

// File: rtl/min_rank_rr_select.sv
// ----------------------------------------------------------------------------
// min_rank_rr_select
// Combinational selector: picks the requesting queue with the smallest
// unsigned rank. Equal ranks are resolved in favour of the first tied
// requester found scanning upward from i_rr_ptr (modulo NUM_QUEUES).
// Ports:
//   i_req      per-queue request
//   i_rank     packed ranks, queue i at [i*RANK_WIDTH +: RANK_WIDTH]
//   i_rr_ptr   round-robin start position
//   o_winner   index of the selected queue (0 when nothing requests)
//   o_any_req  at least one queue requests
// ----------------------------------------------------------------------------
module min_rank_rr_select #(
    parameter int NUM_QUEUES = 5,
    parameter int RANK_WIDTH = 16,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_QUEUES-1:0]            i_req,
    input  logic [NUM_QUEUES*RANK_WIDTH-1:0] i_rank,
    input  logic [IDX_W-1:0]                 i_rr_ptr,
    output logic [IDX_W-1:0]                 o_winner,
    output logic                             o_any_req
);

    int                    w_base;
    int                    w_q;
    logic                  w_found;
    logic [RANK_WIDTH-1:0] w_best;

    // Scan starts at rr_ptr and only a strictly smaller rank replaces the
    // current best, so the earliest tied requester in scan order wins.
    always_comb begin
        w_base   = (int'(i_rr_ptr) < NUM_QUEUES) ? int'(i_rr_ptr) : 0;
        w_q      = 0;
        w_found  = 1'b0;
        w_best   = '1;
        o_winner = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            w_q = w_base + k;
            if (w_q >= NUM_QUEUES) begin
                w_q = w_q - NUM_QUEUES;
            end
            if (i_req[w_q] && (!w_found || (i_rank[w_q*RANK_WIDTH +: RANK_WIDTH] < w_best))) begin
                w_found  = 1'b1;
                w_best   = i_rank[w_q*RANK_WIDTH +: RANK_WIDTH];
                o_winner = IDX_W'(w_q);
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/pifo_dequeue_arbiter.sv
// ----------------------------------------------------------------------------
// pifo_dequeue_arbiter
// Packet-granular dequeue arbiter sharing one packet-buffer read stream
// between NUM_QUEUES output queues. Lowest rank wins, ties rotate. A grant
// is held for the whole packet until the tlast beat is handshaked or the
// no-beat watchdog expires. At least one idle cycle separates grants.
// Ports:
//   axis_aclk / axis_resetn   clock, async active-low reset
//   enable                    allow new grants (sampled in IDLE only)
//   s_req, s_rank             per-queue head request and rank
//   s_beat_valid/ready/last   handshake of the shared read stream
//   m_grant, m_grant_valid,   registered one-hot grant, active flag,
//   m_grant_idx               and binary index of the granted queue
//   grant_count               packets granted
//   timeout_count             watchdog-forced releases
//   busy_cycles               cycles spent holding a grant
// ----------------------------------------------------------------------------
module pifo_dequeue_arbiter #(
    parameter int  NUM_QUEUES     = pifo_sched_pkg::NUM_QUEUES,
    parameter int  RANK_WIDTH     = pifo_sched_pkg::RANK_WIDTH,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter int  CNT_WIDTH      = 32,
    localparam int IDX_W          = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                             axis_aclk,
    input  logic                             axis_resetn,
    input  logic                             enable,
    input  logic [NUM_QUEUES-1:0]            s_req,
    input  logic [NUM_QUEUES*RANK_WIDTH-1:0] s_rank,
    input  logic                             s_beat_valid,
    input  logic                             s_beat_ready,
    input  logic                             s_beat_last,
    output logic [NUM_QUEUES-1:0]            m_grant,
    output logic                             m_grant_valid,
    output logic [IDX_W-1:0]                 m_grant_idx,
    output logic [CNT_WIDTH-1:0]             grant_count,
    output logic [CNT_WIDTH-1:0]             timeout_count,
    output logic [CNT_WIDTH-1:0]             busy_cycles
);

    import pifo_sched_pkg::*;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_gidx;
    logic [NUM_QUEUES-1:0] r_grant;
    logic                  r_grant_valid;
    logic [CNT_WIDTH-1:0]  r_grant_count;
    logic [CNT_WIDTH-1:0]  r_timeout_count;
    logic [CNT_WIDTH-1:0]  r_busy_cycles;

    logic [IDX_W-1:0]      w_winner;
    logic                  w_any_req;
    logic [NUM_QUEUES-1:0] w_onehot;
    logic [IDX_W-1:0]      w_gidx_inc;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_wd_fire;
    logic                  w_start;
    logic                  w_release;
    logic                  w_timeout;

    assign w_beat      = s_beat_valid & s_beat_ready;
    assign w_last_beat = w_beat & s_beat_last;

    min_rank_rr_select #(
        .NUM_QUEUES (NUM_QUEUES),
        .RANK_WIDTH (RANK_WIDTH),
        .IDX_W      (IDX_W)
    ) u_select (
        .i_req      (s_req),
        .i_rank     (s_rank),
        .i_rr_ptr   (r_rr_ptr),
        .o_winner   (w_winner),
        .o_any_req  (w_any_req)
    );

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            w_onehot[i] = (w_winner == IDX_W'(i));
        end
    end

    // Round-robin pointer moves one past the queue just served.
    assign w_gidx_inc = (r_gidx == IDX_W'(NUM_QUEUES - 1)) ? '0 : r_gidx + 1'b1;

    // ------------------------------------------------------------------
    // Watchdog: counts BUSY cycles without a beat. The counter is cleared
    // on grant and on every beat, so hitting TIMEOUT_CYCLES-1 with no beat
    // in that cycle means TIMEOUT_CYCLES consecutive silent cycles.
    // ------------------------------------------------------------------
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

        logic [WD_W-1:0] r_wd;

        always_ff @(posedge axis_aclk or negedge axis_resetn) begin
            if (!axis_resetn) begin
                r_wd <= '0;
            end else if (r_state != ST_BUSY || w_beat || w_release) begin
                r_wd <= '0;
            end else if (r_wd != WD_LAST) begin
                r_wd <= r_wd + 1'b1;
            end
        end

        assign w_wd_fire = (r_state == ST_BUSY) && !w_beat && (r_wd == WD_LAST);
    end else begin : g_no_wd
        assign w_wd_fire = 1'b0;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable && w_any_req)         w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last_beat || w_wd_fire)    w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: output strobes. A tlast beat in the watchdog's final cycle is a
    // normal release (w_wd_fire already excludes beat cycles).
    always_comb begin
        w_start   = 1'b0;
        w_release = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: w_start = enable && w_any_req;
            ST_BUSY: begin
                w_release = w_last_beat || w_wd_fire;
                w_timeout = w_wd_fire && !w_last_beat;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant and round-robin registers
    // ------------------------------------------------------------------
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_gidx        <= '0;
            r_rr_ptr      <= '0;
        end else if (w_start) begin
            r_grant       <= w_onehot;
            r_grant_valid <= 1'b1;
            r_gidx        <= w_winner;
        end else if (w_release) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_gidx_inc;
        end
    end

    // Statistics, free-running and wrapping
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_grant_count   <= '0;
            r_timeout_count <= '0;
            r_busy_cycles   <= '0;
        end else begin
            if (w_start)             r_grant_count   <= r_grant_count + 1'b1;
            if (w_timeout)           r_timeout_count <= r_timeout_count + 1'b1;
            if (r_state == ST_BUSY)  r_busy_cycles   <= r_busy_cycles + 1'b1;
        end
    end

    assign m_grant       = r_grant;
    assign m_grant_valid = r_grant_valid;
    assign m_grant_idx   = r_gidx;
    assign grant_count   = r_grant_count;
    assign timeout_count = r_timeout_count;
    assign busy_cycles   = r_busy_cycles;

endmodule
